// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the RISC-V core.
// Arbitrates per-stage hold requests, jump redirects and trap redirects. It drives one
// PC-redirect port plus per-stage hold and flush vectors. A jump that arrives while older
// stages are stalled is deferred. Every redirect is followed by FLUSH_CYCLES fetch bubbles.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   hold_req_i     per-stage hold requests (stage 0 = fetch, higher index = older)
//   jump_en_i      one-cycle jump request from JUMP_STAGE
//   jump_addr_i    jump target
//   trap_en_i      one-cycle trap/interrupt redirect request
//   trap_addr_i    trap target
//   pc_redirect_o  PC generator loads pc_addr_o this cycle
//   pc_addr_o      redirect target
//   hold_o         per-stage hold
//   flush_o        per-stage bubble insert (overrides hold_o)
//   busy_o         jump pending or bubbles outstanding
//   err_o          one-cycle pulse: a jump was dropped by a collision
module pipe_ctrl #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned NUM_STAGES   = 4,
    parameter int unsigned JUMP_STAGE   = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] hold_req_i,
    input  logic                  jump_en_i,
    input  logic [ADDR_W-1:0]     jump_addr_i,
    input  logic                  trap_en_i,
    input  logic [ADDR_W-1:0]     trap_addr_i,
    output logic                  pc_redirect_o,
    output logic [ADDR_W-1:0]     pc_addr_o,
    output logic [NUM_STAGES-1:0] hold_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [2:0] BubReload = 3'(FLUSH_CYCLES);

    logic                  r_pend_vld;
    logic [ADDR_W-1:0]     r_pend_addr;
    logic [2:0]            r_bub_cnt;
    logic                  r_err;

    logic                  w_pend_vld_nxt;
    logic [ADDR_W-1:0]     w_pend_addr_nxt;
    logic [2:0]            w_bub_cnt_nxt;
    logic                  w_err_nxt;

    logic                  w_stall_old;
    logic [NUM_STAGES-1:0] w_hold;
    logic [NUM_STAGES-1:0] w_jump_flush;
    logic                  w_redirect;
    logic [ADDR_W-1:0]     w_addr;
    logic [NUM_STAGES-1:0] w_flush;

    // Stall propagation towards younger stages, and the jump flush mask (stages younger
    // than the resolving stage).
    always_comb begin
        w_stall_old  = 1'b0;
        w_hold       = '0;
        w_jump_flush = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (k > JUMP_STAGE) begin
                w_stall_old = w_stall_old | hold_req_i[k];
            end
            if (k < JUMP_STAGE) begin
                w_jump_flush[k] = 1'b1;
            end
            for (int unsigned j = 0; j < NUM_STAGES; j++) begin
                if (j >= k) begin
                    w_hold[k] = w_hold[k] | hold_req_i[j];
                end
            end
        end
    end

    // Redirect arbitration and next-state.
    always_comb begin
        w_redirect      = 1'b0;
        w_addr          = '0;
        w_flush         = '0;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_addr_nxt = r_pend_addr;
        w_bub_cnt_nxt   = r_bub_cnt;
        w_err_nxt       = 1'b0;

        if (trap_en_i) begin
            // Trap wins unconditionally; any pending jump is discarded.
            w_redirect     = 1'b1;
            w_addr         = trap_addr_i;
            w_flush        = '1;
            w_pend_vld_nxt = 1'b0;
            w_bub_cnt_nxt  = BubReload;
        end else if (r_pend_vld && !w_stall_old) begin
            // Older pending jump issues; a same-cycle new jump is dropped.
            w_redirect     = 1'b1;
            w_addr         = r_pend_addr;
            w_flush        = w_jump_flush;
            w_pend_vld_nxt = 1'b0;
            w_bub_cnt_nxt  = BubReload;
            w_err_nxt      = jump_en_i;
        end else if (jump_en_i && !w_stall_old) begin
            w_redirect     = 1'b1;
            w_addr         = jump_addr_i;
            w_flush        = w_jump_flush;
            w_bub_cnt_nxt  = BubReload;
        end else if (jump_en_i) begin
            // Deferred; a newer jump overwrites an older pending one.
            w_pend_vld_nxt  = 1'b1;
            w_pend_addr_nxt = jump_addr_i;
            w_err_nxt       = r_pend_vld;
        end

        if (!w_redirect && (r_bub_cnt != 3'd0)) begin
            w_flush[0]    = 1'b1;
            w_bub_cnt_nxt = r_bub_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_bub_cnt   <= 3'd0;
            r_err       <= 1'b0;
        end else begin
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_bub_cnt   <= w_bub_cnt_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // While reset is asserted every stage is flushed and nothing else is driven.
    always_comb begin
        if (!rst_n) begin
            pc_redirect_o = 1'b0;
            pc_addr_o     = '0;
            hold_o        = '0;
            flush_o       = '1;
            busy_o        = 1'b0;
            err_o         = 1'b0;
        end else begin
            pc_redirect_o = w_redirect;
            pc_addr_o     = w_addr;
            hold_o        = w_hold;
            flush_o       = w_flush;
            busy_o        = r_pend_vld | (r_bub_cnt != 3'd0);
            err_o         = r_err;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: two instances (FLUSH_CYCLES=1 and 3) share all inputs. Each
// cycle both are compared against a behavioural model of the redirect rules. Directed
// steps from the test plan come first, then a randomized run.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  hold_req;
    logic        jen;
    logic [31:0] jaddr;
    logic        ten;
    logic [31:0] taddr;

    logic        redir [2];
    logic [31:0] addr  [2];
    logic [3:0]  hold  [2];
    logic [3:0]  flush [2];
    logic        busy  [2];
    logic        err   [2];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state per instance
    int          fc    [2];
    bit          m_pv  [2];
    logic [31:0] m_pa  [2];
    int          m_bub [2];
    bit          m_err [2];
    bit          nx_pv [2];
    logic [31:0] nx_pa [2];
    int          nx_bub[2];
    bit          nx_err[2];

    // Observed values at the last sample point (instance with FLUSH_CYCLES=1)
    logic        last_redir;
    logic [31:0] last_addr;
    logic [3:0]  last_hold;
    logic [3:0]  last_flush;
    logic        last_busy;
    logic        last_err;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .NUM_STAGES(4), .JUMP_STAGE(2), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hold_req_i(hold_req),
        .jump_en_i(jen), .jump_addr_i(jaddr), .trap_en_i(ten), .trap_addr_i(taddr),
        .pc_redirect_o(redir[0]), .pc_addr_o(addr[0]), .hold_o(hold[0]),
        .flush_o(flush[0]), .busy_o(busy[0]), .err_o(err[0])
    );

    pipe_ctrl #(.ADDR_W(32), .NUM_STAGES(4), .JUMP_STAGE(2), .FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .hold_req_i(hold_req),
        .jump_en_i(jen), .jump_addr_i(jaddr), .trap_en_i(ten), .trap_addr_i(taddr),
        .pc_redirect_o(redir[1]), .pc_addr_o(addr[1]), .hold_o(hold[1]),
        .flush_o(flush[1]), .busy_o(busy[1]), .err_o(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pv[d] = 1'b0; m_pa[d] = '0; m_bub[d] = 0; m_err[d] = 1'b0;
        end
    endtask

    // Expected outputs from the redirect rules, plus the next model state.
    task automatic model_eval(input int d);
        bit          stall;
        bit          rd;
        logic [31:0] ea;
        logic [3:0]  ef;
        logic [3:0]  eh;
        stall = (hold_req >> 3) != 0;
        rd    = 1'b0;
        ea    = '0;
        ef    = '0;
        for (int k = 0; k < 4; k++) eh[k] = (hold_req >> k) != 0;
        nx_pv[d]  = m_pv[d];
        nx_pa[d]  = m_pa[d];
        nx_bub[d] = m_bub[d];
        nx_err[d] = 1'b0;
        if (ten) begin
            rd = 1'b1; ea = taddr; ef = 4'b1111;
            nx_pv[d] = 1'b0; nx_bub[d] = fc[d];
        end else if (!stall && (m_pv[d] || jen)) begin
            rd = 1'b1; ea = m_pv[d] ? m_pa[d] : jaddr; ef = 4'b0011;
            nx_pv[d] = 1'b0; nx_bub[d] = fc[d]; nx_err[d] = m_pv[d] && jen;
        end else if (jen) begin
            nx_err[d] = m_pv[d]; nx_pv[d] = 1'b1; nx_pa[d] = jaddr;
        end
        if (!rd && m_bub[d] > 0) begin
            ef[0] = 1'b1; nx_bub[d] = m_bub[d] - 1;
        end
        chk($sformatf("fc%0d_redirect", fc[d]), 32'(redir[d]), 32'(rd));
        chk($sformatf("fc%0d_addr", fc[d]), addr[d], ea);
        chk($sformatf("fc%0d_hold", fc[d]), 32'(hold[d]), 32'(eh));
        chk($sformatf("fc%0d_flush", fc[d]), 32'(flush[d]), 32'(ef));
        chk($sformatf("fc%0d_busy", fc[d]), 32'(busy[d]), 32'(m_pv[d] || m_bub[d] > 0));
        chk($sformatf("fc%0d_err", fc[d]), 32'(err[d]), 32'(m_err[d]));
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic step(input logic [3:0] h, input logic je, input logic [31:0] ja,
                        input logic te, input logic [31:0] ta);
        hold_req = h; jen = je; jaddr = ja; ten = te; taddr = ta;
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_eval(d);
        last_redir = redir[0]; last_addr = addr[0]; last_hold = hold[0];
        last_flush = flush[0]; last_busy = busy[0]; last_err = err[0];
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_pv[d] = nx_pv[d]; m_pa[d] = nx_pa[d]; m_bub[d] = nx_bub[d]; m_err[d] = nx_err[d];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Outputs forced while reset is low (checked with no clock edge required).
    task automatic reset_check(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_fc%0d_redirect", tag, fc[d]), 32'(redir[d]), 32'h0);
            chk($sformatf("%s_fc%0d_addr", tag, fc[d]), addr[d], 32'h0);
            chk($sformatf("%s_fc%0d_hold", tag, fc[d]), 32'(hold[d]), 32'h0);
            chk($sformatf("%s_fc%0d_flush", tag, fc[d]), 32'(flush[d]), 32'hF);
            chk($sformatf("%s_fc%0d_busy", tag, fc[d]), 32'(busy[d]), 32'h0);
        end
    endtask

    // Asynchronous reset pulse entered mid-cycle; released on a falling edge.
    task automatic async_reset(input string tag);
        #1;
        hold_req = 4'b1010; jen = 1'b0; ten = 1'b0; jaddr = '0; taddr = '0;
        rst_n = 1'b0;
        #1;
        reset_check(tag);
        model_reset();
        @(posedge clk);
        hold_req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fc[0] = 1; fc[1] = 3;
        model_reset();
        rst_n = 1'b0;
        hold_req = 4'b1010; jen = 1'b0; jaddr = '0; ten = 1'b0; taddr = '0;
        #3;
        reset_check("por");
        hold_req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain jump
        step(4'b0000, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("plain_redirect", 32'(last_redir), 32'h1);
        chk("plain_addr", last_addr, 32'h100);
        chk("plain_flush", 32'(last_flush), 32'h3);
        step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("plain_bubble", 32'(last_flush), 32'h1);
        chk("plain_busy", 32'(last_busy), 32'h1);
        step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("plain_idle_busy", 32'(last_busy), 32'h0);
        idle(3);

        // Hold propagation
        step(4'b0100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("hold_0100", 32'(last_hold), 32'h7);
        step(4'b1000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("hold_1000", 32'(last_hold), 32'hF);

        // Deferred jump
        step(4'b1000, 1'b1, 32'h200, 1'b0, 32'h0);
        chk("defer_c1_redirect", 32'(last_redir), 32'h0);
        step(4'b1000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("defer_c2_busy", 32'(last_busy), 32'h1);
        step(4'b1000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("defer_c3_redirect", 32'(last_redir), 32'h0);
        step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("defer_issue_addr", last_addr, 32'h200);
        chk("defer_issue_flush", 32'(last_flush), 32'h3);
        idle(4);

        // Trap override of a pending jump
        step(4'b1000, 1'b1, 32'h200, 1'b0, 32'h0);
        step(4'b1000, 1'b0, 32'h0, 1'b1, 32'h8);
        chk("trap_addr", last_addr, 32'h8);
        chk("trap_flush", 32'(last_flush), 32'hF);
        step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("trap_no_stale", 32'(last_redir), 32'h0);
        idle(4);

        // Collision: pending issues, new jump dropped
        step(4'b1000, 1'b1, 32'h200, 1'b0, 32'h0);
        step(4'b0000, 1'b1, 32'h300, 1'b0, 32'h0);
        chk("coll_addr", last_addr, 32'h200);
        step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("coll_err", 32'(last_err), 32'h1);
        chk("coll_no_redirect", 32'(last_redir), 32'h0);
        idle(4);

        // Async reset mid-bubble (FLUSH_CYCLES=3 instance still counting)
        step(4'b0000, 1'b1, 32'h400, 1'b0, 32'h0);
        step(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        async_reset("rst_bubble");
        idle(3);

        // Async reset with a jump pending
        step(4'b1000, 1'b1, 32'h500, 1'b0, 32'h0);
        async_reset("rst_pending");
        idle(3);
        chk("rst_pending_no_redirect", 32'(last_redir), 32'h0);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), $urandom_range(0, 3) == 0, $urandom,
                 $urandom_range(0, 15) == 0, $urandom);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
